// File: rtl/fg_config_loader_if.sv
// Byte-stream handshake between the serial front end and the configuration loader.
// The signal names are seen from the loader side: data_i and valid_i go in, and ready_o comes out.
interface fg_config_loader_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/fg_config_loader.sv
// Framed byte loader: SYNC_BYTE, NBYTES payload bytes (MSB first), then an XOR checksum byte.
// Only a frame whose checksum matches is copied to cr_bus_o, so the generator never sees a partial update.
module fg_config_loader #(
    parameter int                             CONFIG_REG_BITWIDTH = 56,
    parameter logic [7:0]                     SYNC_BYTE           = 8'hA5,
    parameter int                             TIMEOUT_CYCLES      = 1024,
    parameter int                             TIMEOUT_BITWIDTH    = 11,
    parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG        = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    fg_config_loader_if.slave              s_if,
    input  logic                           clr_err_i,
    output logic [CONFIG_REG_BITWIDTH-1:0] cr_bus_o,
    output logic                           cr_update_o,
    output logic                           busy_o,
    output logic [1:0]                     err_o
);
    localparam int NBYTES = CONFIG_REG_BITWIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK, ST_COMMIT} state_t;

    state_t                         r_state, w_state_next;
    logic [CONFIG_REG_BITWIDTH-1:0] r_shadow, r_cr_bus;
    logic [7:0]                     r_chk;
    logic [CNT_W-1:0]               r_count;
    logic [TIMEOUT_BITWIDTH-1:0]    r_tmo_cnt;
    logic [1:0]                     r_err, w_err_set;
    logic                           r_cr_update;
    logic                           w_ready, w_accept, w_tmo_hit;

    assign w_ready   = (r_state != ST_COMMIT);
    assign w_accept  = s_if.valid_i && w_ready;
    assign w_tmo_hit = (r_tmo_cnt == TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1));

    assign s_if.ready_o = w_ready;
    assign busy_o       = (r_state != ST_IDLE);
    assign cr_bus_o     = r_cr_bus;
    assign cr_update_o  = r_cr_update;
    assign err_o        = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every signal assigned here gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_err_set    = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && s_if.data_i == SYNC_BYTE) w_state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    if (r_count == CNT_W'(NBYTES - 1)) w_state_next = ST_CHECK;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_IDLE;
                    w_err_set[1] = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    if (s_if.data_i == r_chk) begin
                        w_state_next = ST_COMMIT;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_err_set[0] = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_next = ST_IDLE;
                    w_err_set[1] = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow    <= '0;
            r_chk       <= '0;
            r_count     <= '0;
            r_tmo_cnt   <= '0;
            r_err       <= '0;
            r_cr_bus    <= RESET_CONFIG;
            r_cr_update <= 1'b0;
        end else begin
            r_cr_update <= (r_state == ST_COMMIT);
            if (r_state == ST_COMMIT) r_cr_bus <= r_shadow;

            // A new error sets its bit even when a clear is requested on the same edge.
            r_err <= (clr_err_i ? 2'b00 : r_err) | w_err_set;

            if ((r_state == ST_PAYLOAD || r_state == ST_CHECK) && !w_accept && !w_tmo_hit)
                r_tmo_cnt <= r_tmo_cnt + TIMEOUT_BITWIDTH'(1);
            else
                r_tmo_cnt <= '0;

            if (r_state == ST_IDLE && w_accept && s_if.data_i == SYNC_BYTE) begin
                r_shadow <= '0;
                r_chk    <= '0;
                r_count  <= '0;
            end else if (r_state == ST_PAYLOAD && w_accept) begin
                r_shadow <= {r_shadow[CONFIG_REG_BITWIDTH-9:0], s_if.data_i};
                r_chk    <= r_chk ^ s_if.data_i;
                r_count  <= r_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fg_config_loader.sv
// Directed bench for fg_config_loader using hand-computed frames and checksums.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_fg_config_loader;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clr_err_i = 1'b0;
    logic [55:0] cr_bus_o;
    logic        cr_update_o, busy_o;
    logic [1:0]  err_o;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_upd    = 0;
    int          upd_mark;

    fg_config_loader_if u_if ();

    fg_config_loader u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_if        (u_if.slave),
        .clr_err_i   (clr_err_i),
        .cr_bus_o    (cr_bus_o),
        .cr_update_o (cr_update_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (cr_update_o) n_upd++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one byte and returns 1 ns after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done = 0;
        u_if.data_i  = b;
        u_if.valid_i = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            rdy = u_if.ready_o;
            @(posedge clk_i);
            if (rdy) done = 1;
        end
        #1;
        u_if.valid_i = 1'b0;
        if (!done) check("accept_bound", 64'd0, 64'd1);
    endtask

    task automatic send_payload(input logic [55:0] p, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(p[55 - 8*i -: 8]);
    endtask

    localparam logic [55:0] P1 = 56'h80051000407F00;
    localparam logic [55:0] P2 = 56'h11223344556677;
    localparam logic [55:0] P3 = 56'hA5A5A5A5A5A5A5;
    localparam logic [55:0] P4 = 56'h123456789ABCDE;

    initial begin
        u_if.data_i  = 8'h00;
        u_if.valid_i = 1'b0;
        #12;
        check("rst_cr_bus", cr_bus_o, 56'h0);
        check("rst_ready", u_if.ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 2'b00);
        check("rst_update", cr_update_o, 1'b0);
        #11 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Good frame: commit one cycle after the checksum edge, ready low for that cycle.
        upd_mark = n_upd;
        send_byte(8'hA5); send_payload(P1, 0, 6); send_byte(8'hAA);
        check("t1_commit_ready", u_if.ready_o, 1'b0);
        check("t1_commit_busy", busy_o, 1'b1);
        check("t1_bus_before", cr_bus_o, 56'h0);
        @(posedge clk_i); #1;
        check("t1_bus", cr_bus_o, P1);
        check("t1_update_hi", cr_update_o, 1'b1);
        check("t1_ready_back", u_if.ready_o, 1'b1);
        check("t1_err", err_o, 2'b00);
        @(posedge clk_i); #1;
        check("t1_update_lo", cr_update_o, 1'b0);
        check("t1_update_cnt", n_upd - upd_mark, 1);

        // Bad checksum: error, no commit; then clear and a good frame still commits.
        upd_mark = n_upd;
        send_byte(8'hA5); send_payload(P1, 0, 6); send_byte(8'hAB);
        check("t2_err", err_o, 2'b01);
        check("t2_busy", busy_o, 1'b0);
        repeat (3) @(posedge clk_i); #1;
        check("t2_bus_kept", cr_bus_o, P1);
        check("t2_no_update", n_upd - upd_mark, 0);
        check("t2_err_sticky", err_o, 2'b01);
        clr_err_i = 1'b1; @(posedge clk_i); #1; clr_err_i = 1'b0;
        check("t2_err_clr", err_o, 2'b00);
        send_byte(8'hA5); send_payload(P2, 0, 6); send_byte(8'h00);
        @(posedge clk_i); #1;
        check("t2_recover_bus", cr_bus_o, P2);

        // Garbage ahead of a frame is dropped; sync value inside payload is plain data.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        check("t3_garbage_idle", busy_o, 1'b0);
        send_byte(8'hA5); send_payload(P1, 0, 6); send_byte(8'hAA);
        @(posedge clk_i); #1;
        check("t3_bus", cr_bus_o, P1);
        send_byte(8'hA5); send_payload(P3, 0, 6); send_byte(8'hA5);
        @(posedge clk_i); #1;
        check("t3_a5_bus", cr_bus_o, P3);
        check("t3_err", err_o, 2'b00);

        // Timeout: 1024 idle cycles aborts, 1023 does not.
        upd_mark = n_upd;
        send_byte(8'hA5); send_payload(P1, 0, 2);
        repeat (1023) @(posedge clk_i); #1;
        check("t4_busy_1023", busy_o, 1'b1);
        check("t4_err_1023", err_o, 2'b00);
        @(posedge clk_i); #1;
        check("t4_err_tmo", err_o, 2'b10);
        check("t4_busy_tmo", busy_o, 1'b0);
        check("t4_bus_kept", cr_bus_o, P3);
        send_byte(8'hA5); send_payload(P4, 0, 2);
        repeat (1023) @(posedge clk_i); #1;
        send_payload(P4, 3, 6); send_byte(8'hF0);
        @(posedge clk_i); #1;
        check("t4_gap_bus", cr_bus_o, P4);
        check("t4_gap_err", err_o, 2'b10);
        check("t4_update_cnt", n_upd - upd_mark, 1);

        // Sync held during COMMIT is taken the cycle after; clear coinciding with a checksum error.
        send_byte(8'hA5); send_payload(P1, 0, 6); send_byte(8'hAA);
        u_if.data_i  = 8'hA5;
        u_if.valid_i = 1'b1;
        check("t5_commit_ready", u_if.ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("t5_not_taken", busy_o, 1'b0);
        check("t5_update", cr_update_o, 1'b1);
        @(posedge clk_i); #1;
        check("t5_taken", busy_o, 1'b1);
        u_if.valid_i = 1'b0;
        send_payload(P1, 0, 6);
        clr_err_i = 1'b1;
        send_byte(8'h55);
        clr_err_i = 1'b0;
        check("t5_set_wins", err_o, 2'b01);
        check("t5_bus_kept", cr_bus_o, P1);

        // Async reset mid-payload discards the frame and restores the reset configuration.
        upd_mark = n_upd;
        send_byte(8'hA5); send_payload(P2, 0, 3);
        rst_i = 1'b1; #2;
        check("t6_rst_bus", cr_bus_o, 56'h0);
        check("t6_rst_busy", busy_o, 1'b0);
        check("t6_rst_err", err_o, 2'b00);
        rst_i = 1'b0;
        send_payload(P2, 4, 6); send_byte(8'h00);
        repeat (2) @(posedge clk_i); #1;
        check("t6_no_update", n_upd - upd_mark, 0);
        check("t6_no_err", err_o, 2'b00);
        check("t6_bus", cr_bus_o, 56'h0);
        check("t6_idle", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
